// File: rtl/toggle_check_pkg.sv
// Shared types and default widths for the toggle-stimulus sequencer and its
// rise-after-odd property checker.
package toggle_check_pkg;
  localparam int CYC_W_DEF = 16;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/rise_after_odd_checker.sv
// Checks "odd cycle index implies no rising edge of val on the next cycle",
// counting violations (saturating) and capturing the cycle of the first one.
module rise_after_odd_checker
  import toggle_check_pkg::*;
#(
  parameter int CYC_W = CYC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic             leave_i,
  input  logic             clear_i,
  input  logic [CYC_W-1:0] cyc_i,
  input  logic             val_i,
  output logic             violation_o,
  output logic             fail_pulse_o,
  output logic [CNT_W-1:0] fail_cnt_o,
  output logic [CYC_W-1:0] first_fail_cyc_o
);
  logic             arm_q;
  logic             val_q;
  logic             fail_pulse_q;
  logic [CNT_W-1:0] fail_cnt_q;
  logic [CYC_W-1:0] first_fail_q;
  logic             violation_c;

  // arm_q/val_q describe the previous RUN cycle: was its index odd, and what was val.
  assign violation_c = run_i & arm_q & ~val_q & val_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_q        <= 1'b0;
      val_q        <= 1'b0;
      fail_pulse_q <= 1'b0;
      fail_cnt_q   <= '0;
      first_fail_q <= '0;
    end else begin
      fail_pulse_q <= violation_c;
      if (clear_i) begin
        arm_q        <= 1'b0;
        val_q        <= 1'b0;
        fail_cnt_q   <= '0;
        first_fail_q <= '0;
      end else if (run_i) begin
        arm_q <= leave_i ? 1'b0 : cyc_i[0];
        val_q <= val_i;
        if (violation_c) begin
          if (fail_cnt_q != '1) fail_cnt_q <= fail_cnt_q + 1'b1;
          if (fail_cnt_q == '0) first_fail_q <= cyc_i;
        end
      end
    end
  end

  assign violation_o      = violation_c;
  assign fail_pulse_o     = fail_pulse_q;
  assign fail_cnt_o       = fail_cnt_q;
  assign first_fail_cyc_o = first_fail_q;
endmodule

// File: rtl/toggle_check_sequencer.sv
// Sequences a bounded toggle-stimulus run and reports the property checker's
// verdict when the run completes.
module toggle_check_sequencer
  import toggle_check_pkg::*;
#(
  parameter int CYC_W = CYC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CYC_W-1:0] max_cyc_i,
  input  logic             inject_i,
  output logic             val_o,
  output logic [CYC_W-1:0] cyc_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             fail_pulse_o,
  output logic [CNT_W-1:0] fail_cnt_o,
  output logic [CYC_W-1:0] first_fail_cyc_o
);
  state_e           state_q;
  logic [CYC_W-1:0] cyc_q;
  logic [CYC_W-1:0] max_q;
  logic             stim_q;
  logic             done_q;
  logic             pass_q;

  logic             run_c;
  logic             start_c;
  logic             last_c;
  logic             leave_c;
  logic             violation_c;

  assign run_c   = (state_q == RUN);
  assign start_c = start_i & ~run_c;
  assign last_c  = run_c & ~abort_i & (cyc_q == max_q);
  assign leave_c = (run_c & abort_i) | last_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      max_q   <= '0;
      stim_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q <= RUN;
            cyc_q   <= '0;
            stim_q  <= 1'b0;
            max_q   <= max_cyc_i;
            pass_q  <= 1'b0;
          end
        end
        RUN: begin
          if (abort_i) begin
            state_q <= IDLE;
          end else if (cyc_q == max_q) begin
            // The final cycle's own violation must be folded into the verdict.
            state_q <= DONE;
            done_q  <= 1'b1;
            pass_q  <= (fail_cnt_o == '0) & ~violation_c;
          end else begin
            cyc_q  <= cyc_q + 1'b1;
            stim_q <= inject_i ? stim_q : ~stim_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  rise_after_odd_checker #(
    .CYC_W(CYC_W),
    .CNT_W(CNT_W)
  ) u_checker (
    .clk              (clk),
    .rst_n            (rst_n),
    .run_i            (run_c),
    .leave_i          (leave_c),
    .clear_i          (start_c),
    .cyc_i            (cyc_q),
    .val_i            (stim_q),
    .violation_o      (violation_c),
    .fail_pulse_o     (fail_pulse_o),
    .fail_cnt_o       (fail_cnt_o),
    .first_fail_cyc_o (first_fail_cyc_o)
  );

  assign val_o  = stim_q;
  assign cyc_o  = cyc_q;
  assign busy_o = run_c;
  assign done_o = done_q;
  assign pass_o = pass_q;
endmodule
